// File: rtl/instr_encoder_loader.sv
// Instruction encoder / IMEM loader.
// Packs field bundles into 20-bit instruction words on acceptance, buffers them in
// a small FIFO and streams them into instruction memory at consecutive addresses.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. valid may not depend on ready; once raised it is held with stable payload
// until the transfer. This applies to in_valid/in_ready (bundle in) and to
// mem_we/mem_ready (word out), where mem_we plays the valid role.
module instr_encoder_loader #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_op,
  input  logic [1:0]        in_fa,
  input  logic [1:0]        in_fb,
  input  logic [1:0]        in_fc,
  input  logic [11:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [19:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_trunc,
  output logic [1:0]        state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [19:0]      fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty, full, push, pop;
  logic [19:0]      enc_word;
  logic             enc_trunc;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign in_ready  = (state == LOAD) && !full;
  assign push      = in_valid && in_ready;
  assign mem_we    = (state != IDLE) && !empty;
  assign pop       = mem_we && mem_ready;
  assign mem_wdata = fifo_mem[rd_ptr];
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Field packing per format, plus detection of nonzero immediate bits that do not fit.
  always_comb begin
    enc_word  = '0;
    enc_trunc = 1'b0;
    case (in_fmt)
      2'd0: enc_word = {in_op, in_fa, in_fb, in_fc, 8'b0};
      2'd1: begin
        enc_word  = {in_op, in_fa, in_fb, in_imm[9:0]};
        enc_trunc = |in_imm[11:10];
      end
      2'd2: enc_word = {in_op, in_fa, in_imm};
      default: begin
        enc_word  = {in_op, in_imm[10:0], 3'b0};
        enc_trunc = in_imm[11];
      end
    endcase
  end

  // Next-state logic: a session runs IDLE -> LOAD -> DRAIN -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (push && in_last) state_next = DRAIN;
      DRAIN:   if (empty || (count == CNT_W'(1) && pop)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and registered done pulse (coincides with the return to IDLE).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == DRAIN) && (state_next == IDLE);
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: words are encoded as they are written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

  // Write address and sticky truncation flag, both re-armed by start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr  <= BASE;
      err_trunc <= 1'b0;
    end else begin
      if (state == IDLE && start) mem_addr <= BASE;
      else if (pop)               mem_addr <= mem_addr + ADDR_W'(1);
      if (state == IDLE && start)  err_trunc <= 1'b0;
      else if (push && enc_trunc)  err_trunc <= 1'b1;
    end
  end

endmodule
